lsu_ctrl: RTL and testbench

- Load/store unit between the execute stage and the data memory port (`data_src` data side).
- Accepts one load or store request at a time from execute and checks alignment.
- Drives the memory request signals (`mem_en`, `addr`, `wdata`, `mem_rw`, `sign_ex`, `dw`) and waits for `data_ready` on loads.
- Returns load data or an error to writeback through a valid/ready response buffer.

---
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: alignment check, single-op memory sequencing, timeout,
// and a registered valid/ready response buffer towards writeback.
package lsu_pkg;
    typedef enum logic [1:0] {
        DB = 2'd0,
        DH = 2'd1,
        DW = 2'd2
    } data_width_t;
endpackage

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  data_width_t req_dw,
    input  logic        req_sign,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        sign_ex,
    output data_width_t dw,
    input  logic        data_ready,
    input  logic [31:0] memory
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sign_ex_q, sign_ex_d;
    data_width_t dw_q, dw_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        misaligned;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_dw)
            DH:      misaligned = req_addr[0];
            DW:      misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sign_ex_d    = sign_ex_q;
        dw_d         = dw_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_rd_d    = req_we ? 5'd0 : req_rd;
                    end else begin
                        state_d   = ISSUE;
                        mem_en_d  = 1'b1;
                        mem_rw_d  = req_we;
                        addr_d    = req_addr;
                        wdata_d   = req_wdata;
                        sign_ex_d = req_sign;
                        dw_d      = req_dw;
                        resp_rd_d = req_rd;
                    end
                end
            end
            ISSUE: begin
                mem_en_d = 1'b0;
                cnt_d    = '0;
                state_d  = mem_rw_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (data_ready) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = memory;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Counter parks here, so it saturates instead of wrapping.
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            sign_ex_q    <= 1'b0;
            dw_q         <= DW;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sign_ex_q    <= sign_ex_d;
            dw_q         <= dw_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = rst_n && (state_q == IDLE);
    assign mem_en     = mem_en_q;
    assign mem_rw     = mem_rw_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign sign_ex    = sign_ex_q;
    assign dw         = dw_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected memory ops and responses are
// queued at issue time and checked by independent memory/response monitors.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [31:0] req_addr, req_wdata;
    data_width_t req_dw;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_en, mem_rw, sign_ex, data_ready;
    logic [31:0] addr, wdata, memory;
    data_width_t dw;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dw(req_dw),
        .req_sign(req_sign), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_en(mem_en), .mem_rw(mem_rw), .addr(addr), .wdata(wdata),
        .sign_ex(sign_ex), .dw(dw),
        .data_ready(data_ready), .memory(memory)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        longint      due;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        data_width_t dw;
        logic        sign;
        int          delay;
        logic [31:0] data;
        longint      due;
    } mem_t;

    rsp_t rq[$];
    mem_t mq[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit rr_rand = 0;
    logic rr_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory model: checks each strobe, answers reads after a chosen delay.
    initial begin
        mem_t m;
        data_ready = 1'b0;
        memory = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_en === 1'b1) begin
                chk("mem_expected", 32'(mq.size() != 0), 32'd1);
                m = '{addr: 0, wdata: 0, rw: 1'b1, dw: DW, sign: 0,
                      delay: 0, data: 0, due: 0};
                if (mq.size() != 0) begin
                    m = mq.pop_front();
                    chk("mem_addr", addr, m.addr);
                    chk("mem_rw", 32'(mem_rw), 32'(m.rw));
                    chk("mem_dw", 32'(dw), 32'(m.dw));
                    chk("mem_sign", 32'(sign_ex), 32'(m.sign));
                    chk("mem_lat", 32'(cyc), 32'(m.due));
                    if (m.rw) chk("mem_wdata", wdata, m.wdata);
                end
                @(negedge clk);
                chk("mem_en_pulse", 32'(mem_en), 32'd0);
                if (!m.rw && m.delay != 0) begin
                    repeat (m.delay - 1) @(posedge clk);
                    #1;
                    data_ready = 1'b1;
                    memory = m.data;
                    @(posedge clk);
                    #1;
                    data_ready = 1'b0;
                    memory = $urandom;
                end
            end
        end
    end

    // Response monitor: pops on first sight, then checks hold under stall.
    initial begin
        rsp_t e;
        bit pend = 0;
        logic [31:0] h_rdata;
        logic [4:0] h_rd;
        logic h_err;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pend = 0;
            end else if (resp_valid === 1'b1) begin
                if (!pend) begin
                    chk("resp_expected", 32'(rq.size() != 0), 32'd1);
                    if (rq.size() != 0) begin
                        e = rq.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_rd", 32'(resp_rd), 32'(e.rd));
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        chk("resp_lat", 32'(cyc), 32'(e.due));
                    end
                end else begin
                    chk("hold_rdata", resp_rdata, h_rdata);
                    chk("hold_rd", 32'(resp_rd), 32'(h_rd));
                    chk("hold_err", 32'(resp_err), 32'(h_err));
                end
                h_rdata = resp_rdata;
                h_rd = resp_rd;
                h_err = resp_err;
                pend = (resp_ready !== 1'b1);
            end
        end
    end

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
        end
    end

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input data_width_t w,
                         input logic sg, input logic [4:0] rd,
                         input int delay, input logic [31:0] md,
                         input bit want_rsp);
        bit mis;
        int k;
        longint acc;
        rsp_t r;
        mem_t m;
        mis = (w == DH && a % 2 != 0) || (w == DW && a % 4 != 0);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        req_dw = w;
        req_sign = sg;
        req_rd = rd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ready !== 1'b1 && k < 300);
        if (req_ready !== 1'b1) chk("req_accept", 32'(req_ready), 32'd1);
        acc = cyc;
        if (mis) begin
            r = '{rdata: 0, rd: we ? 5'd0 : rd, err: 1'b1, due: acc + 1};
            if (want_rsp) rq.push_back(r);
        end else begin
            m = '{addr: a, wdata: wd, rw: we, dw: w, sign: sg,
                  delay: delay, data: md, due: acc + 1};
            mq.push_back(m);
            if (!we && want_rsp) begin
                r.rdata = (delay == 0) ? 32'd0 : md;
                r.rd = rd;
                r.err = (delay == 0);
                r.due = acc + 2 + ((delay == 0) ? TIMEOUT : delay);
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((rq.size() != 0 || mq.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(rq.size() + mq.size()), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h40;
        req_wdata = 32'd0;
        req_dw = DW;
        req_sign = 1'b0;
        req_rd = 5'd1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        chk("rst_addr", addr, 32'd0);
        chk("rst_dw", 32'(dw), 32'(DW));
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        issue(1'b0, 32'h100, 32'd0, DW, 1'b0, 5'd5, 2, 32'hDEADBEEF, 1);
        drain();

        issue(1'b1, 32'h103, 32'h7F, DB, 1'b0, 5'd0, 0, 32'd0, 1);
        @(negedge clk);
        chk("st_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("st_ready_t2", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h103, 32'd0, DB, 1'b1, 5'd9, 2, 32'h7F, 1);
        drain();

        issue(1'b0, 32'h101, 32'd0, DH, 1'b0, 5'd3, 0, 32'd0, 1);
        drain();
        issue(1'b1, 32'h102, 32'h1234, DW, 1'b0, 5'd7, 0, 32'd0, 1);
        drain();

        rr_force = 1'b0;
        issue(1'b0, 32'h204, 32'd0, DW, 1'b0, 5'd12, 3, 32'hCAFEF00D, 1);
        k = 0;
        while (resp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        repeat (5) @(posedge clk);
        rr_force = 1'b1;
        drain();

        issue(1'b0, 32'h300, 32'd0, DH, 1'b1, 5'd20, 0, 32'd0, 1);
        drain();
        @(negedge clk);
        chk("to_idle", 32'(req_ready), 32'd1);

        issue(1'b0, 32'h400, 32'd0, DW, 1'b0, 5'd8, 5, 32'h55AA55AA, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("late_dr_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rst_wait_mq", 32'(mq.size()), 32'd0);
        issue(1'b0, 32'h408, 32'd0, DW, 1'b0, 5'd11, 2, 32'h01020304, 1);
        drain();

        rr_rand = 1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int d;
            a = 32'h800 + 32'($urandom_range(0, 255));
            d = $urandom_range(1, 8);
            if (d == 1) d = 0;
            issue(1'($urandom_range(0, 1)), a, $urandom,
                  data_width_t'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  d, $urandom, 1);
        end
        drain();
        rr_rand = 0;
        rr_force = 1'b1;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
